// File: rtl/step_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | step_sequencer_pkg                                                       |
// | Shared lane indices, FSM encoding and step-record sizing.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package step_sequencer_pkg;

    localparam int LANE_LEFT  = 0;
    localparam int LANE_RIGHT = 1;
    localparam int LANE_UP    = 2;
    localparam int LANE_DOWN  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // A table record is {time, lane_mask}.
    function automatic int step_rec_w(input int tw, input int lanes);
        return tw + lanes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_sequencer_ms_tick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | step_sequencer_ms_tick                                                   |
// | Millisecond prescaler with enable and clear; one-cycle tick at terminal. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module step_sequencer_ms_tick #(
    parameter int CLK_PER_MS = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int                c_CW   = $clog2(CLK_PER_MS);
    localparam logic [c_CW-1:0]   c_TERM = c_CW'(CLK_PER_MS - 1);

    logic [c_CW-1:0] r_cnt;

    assign o_tick = i_en && !i_clr && (r_cnt == c_TERM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/step_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | step_sequencer                                                           |
// | Plays a loadable (time, lane-mask) step table against a ms song clock.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module step_sequencer
    import step_sequencer_pkg::*;
#(
    parameter  int LANES      = 4,
    parameter  int DEPTH      = 32,
    parameter  int TW         = 15,
    parameter  int CLK_PER_MS = 50000,
    parameter  int SONG_MS    = 30000,
    parameter  int HOLD_MS    = 250,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             loop,
    input  logic [AW:0]      step_count,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [TW-1:0]    load_time,
    input  logic [LANES-1:0] load_lanes,
    output logic [LANES-1:0] arrows,
    output logic             step_strobe,
    output logic [AW-1:0]    step_idx,
    output logic             busy,
    output logic             lap,
    output logic             done
);

    localparam int               c_RW    = step_rec_w(TW, LANES);
    localparam int               c_HW    = $clog2(HOLD_MS + 1);
    localparam logic [TW-1:0]    c_LAST  = TW'(SONG_MS - 1);
    localparam logic [c_HW-1:0]  c_HOLD  = c_HW'(HOLD_MS);
    localparam logic [AW:0]      c_DEPTH = (AW + 1)'(DEPTH);

    state_t          r_state;
    logic [TW-1:0]   r_time;
    logic [AW:0]     r_ptr;
    logic [AW:0]     r_cnt;
    logic [c_HW-1:0] r_hold;
    logic [c_RW-1:0] r_table [DEPTH];

    logic             w_run;
    logic             w_tick;
    logic [c_RW-1:0]  w_entry;
    logic [TW-1:0]    w_next_time;
    logic             w_end;
    logic             w_fire;
    logic [AW:0]      w_cnt_in;

    // Start has priority over pause, so the start cycle itself never counts.
    assign w_run       = busy && !pause && !start;
    assign w_entry     = r_table[r_ptr[AW-1:0]];
    assign w_next_time = r_time + 1'b1;
    assign w_end       = (r_time == c_LAST);
    // Compare against the song time that this tick advances to.
    assign w_fire      = !w_end && (r_ptr < r_cnt) && (w_entry[c_RW-1:LANES] <= w_next_time);
    assign w_cnt_in    = (step_count > c_DEPTH) ? c_DEPTH : step_count;

    step_sequencer_ms_tick #(
        .CLK_PER_MS (CLK_PER_MS)
    ) u_ms_tick (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_run),
        .i_clr  (start),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (load_en && !busy) begin
            r_table[load_addr] <= {load_time, load_lanes};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_time      <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_hold      <= '0;
            arrows      <= '0;
            step_strobe <= 1'b0;
            step_idx    <= '0;
            busy        <= 1'b0;
            lap         <= 1'b0;
            done        <= 1'b0;
        end else begin
            step_strobe <= 1'b0;
            lap         <= 1'b0;
            if (start) begin
                r_state <= ST_RUN;
                busy    <= 1'b1;
                done    <= 1'b0;
                r_time  <= '0;
                r_ptr   <= '0;
                r_hold  <= '0;
                r_cnt   <= w_cnt_in;
                arrows  <= '0;
            end else begin
                case (r_state)
                    ST_RUN, ST_PAUSED: begin
                        r_state <= pause ? ST_PAUSED : ST_RUN;
                        if (w_tick) begin
                            if (w_end) begin
                                r_time <= '0;
                                r_ptr  <= '0;
                                r_hold <= '0;
                                arrows <= '0;
                                if (loop) begin
                                    lap <= 1'b1;
                                end else begin
                                    r_state <= ST_DONE;
                                    busy    <= 1'b0;
                                    done    <= 1'b1;
                                end
                            end else begin
                                r_time <= w_next_time;
                                if (w_fire) begin
                                    arrows      <= w_entry[LANES-1:0];
                                    step_idx    <= r_ptr[AW-1:0];
                                    step_strobe <= 1'b1;
                                    r_ptr       <= r_ptr + 1'b1;
                                    r_hold      <= c_HOLD;
                                end else if (r_hold != '0) begin
                                    r_hold <= r_hold - 1'b1;
                                    if (r_hold == c_HW'(1)) begin
                                        arrows <= '0;
                                    end
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_step_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_step_sequencer                                                        |
// | Directed scenarios plus random play against a ms-level reference model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_step_sequencer;
    import step_sequencer_pkg::*;

    localparam int LANES = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int TW    = 8;
    localparam int CPM   = 4;
    localparam int SONG  = 40;
    localparam int HOLD  = 3;

    localparam logic [3:0] c_L = 4'b0001 << LANE_LEFT;
    localparam logic [3:0] c_R = 4'b0001 << LANE_RIGHT;
    localparam logic [3:0] c_U = 4'b0001 << LANE_UP;
    localparam logic [3:0] c_D = 4'b0001 << LANE_DOWN;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             pause = 1'b0;
    logic             loop = 1'b0;
    logic [AW:0]      step_count = '0;
    logic             load_en = 1'b0;
    logic [AW-1:0]    load_addr = '0;
    logic [TW-1:0]    load_time = '0;
    logic [LANES-1:0] load_lanes = '0;
    logic [LANES-1:0] arrows;
    logic             step_strobe;
    logic [AW-1:0]    step_idx;
    logic             busy;
    logic             lap;
    logic             done;

    step_sequencer #(
        .LANES(LANES), .DEPTH(DEPTH), .TW(TW),
        .CLK_PER_MS(CPM), .SONG_MS(SONG), .HOLD_MS(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .loop(loop),
        .step_count(step_count), .load_en(load_en), .load_addr(load_addr),
        .load_time(load_time), .load_lanes(load_lanes), .arrows(arrows),
        .step_strobe(step_strobe), .step_idx(step_idx), .busy(busy),
        .lap(lap), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: song position is the count of running clocks since start/lap.
    bit         m_active, m_done, m_strobe, m_lap;
    logic [3:0] m_arrows;
    int         m_idx, m_clk, m_ptr, m_cnt, m_clear_at, ms;
    int         m_time [DEPTH];
    logic [3:0] m_lanes [DEPTH];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 0; m_done = 0; m_strobe = 0; m_lap = 0; m_arrows = 0;
            m_idx = 0; m_clk = 0; m_ptr = 0; m_cnt = 0; m_clear_at = -1;
        end else begin
            m_strobe = 0;
            m_lap = 0;
            if (load_en && !m_active) begin
                m_time[load_addr]  = int'(load_time);
                m_lanes[load_addr] = load_lanes;
            end
            if (start) begin
                m_active = 1; m_done = 0; m_clk = 0; m_ptr = 0;
                m_arrows = 0; m_clear_at = -1;
                m_cnt = (int'(step_count) > DEPTH) ? DEPTH : int'(step_count);
            end else if (m_active && !pause) begin
                m_clk++;
                if (m_clk % CPM == 0) begin
                    ms = m_clk / CPM;
                    if (ms == SONG) begin
                        m_arrows = 0; m_clear_at = -1; m_ptr = 0; m_clk = 0;
                        if (loop) m_lap = 1;
                        else begin m_active = 0; m_done = 1; end
                    end else if (m_ptr < m_cnt && m_time[m_ptr] <= ms) begin
                        m_arrows = m_lanes[m_ptr];
                        m_idx = m_ptr;
                        m_strobe = 1;
                        m_ptr++;
                        m_clear_at = ms + HOLD;
                    end else if (ms == m_clear_at) begin
                        m_arrows = 0;
                        m_clear_at = -1;
                    end
                end
            end
        end
    end

    function automatic logic [11:0] dut_vec();
        return {arrows, step_strobe, step_idx, busy, lap, done};
    endfunction

    function automatic logic [11:0] model_vec();
        logic [31:0] idx;
        idx = m_idx;
        return {m_arrows, m_strobe, idx[2:0], m_active, m_lap, m_done};
    endfunction

    bit         chk_en = 0;
    int         n_strobe = 0, n_lap = 0, n_up = 0;
    logic [3:0] q_l [$];
    int         q_i [$];

    always @(negedge clk) begin
        if (chk_en) check("cycle", 32'(dut_vec()), 32'(model_vec()));
        if (step_strobe) begin
            n_strobe++;
            q_l.push_back(arrows);
            q_i.push_back(int'(step_idx));
        end
        if (lap) n_lap++;
        if (arrows == c_U) n_up++;
    end

    task automatic load(input int a, input int t, input logic [3:0] l);
        load_en = 1'b1;
        load_addr = AW'(a);
        load_time = TW'(t);
        load_lanes = l;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic do_start(input int c);
        step_count = (AW + 1)'(c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, done, 1);
    endtask

    task automatic wait_strobe(input string tag, input int budget);
        int s0, c;
        s0 = n_strobe;
        c = 0;
        while (n_strobe == s0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, 32'(n_strobe != s0), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s0, qb, u0, l0, cyc;
        repeat (2) @(negedge clk);
        check("reset", 32'(dut_vec()), 0);
        rst = 1'b1;
        chk_en = 1;
        for (int a = 0; a < DEPTH; a++) load(a, 200, 4'b0000);

        // Test 1: basic three-step song
        load(0, 5, c_R); load(1, 10, c_L); load(2, 12, c_U);
        s0 = n_strobe; qb = q_l.size(); u0 = n_up;
        do_start(3);
        wait_done("t1_done", 400, cyc);
        check("t1_len", cyc, SONG * CPM);
        check("t1_strobes", n_strobe - s0, 3);
        check("t1_first", q_l[qb], c_R);
        check("t1_second", q_l[qb+1], c_L);
        check("t1_third", q_l[qb+2], c_U);
        check("t1_up_hold", n_up - u0, HOLD * CPM);

        // Test 2: pause for 20 clocks shifts the whole song by 20 clocks
        s0 = n_strobe;
        do_start(3);
        repeat (28) @(negedge clk);
        pause = 1'b1;
        repeat (20) @(negedge clk);
        pause = 1'b0;
        wait_done("t2_done", 400, cyc);
        check("t2_len", cyc + 48, SONG * CPM + 20);
        check("t2_strobes", n_strobe - s0, 3);

        // Test 3: unsorted entries fire on consecutive ticks
        load(0, 8, c_D); load(1, 3, c_L);
        s0 = n_strobe; qb = q_l.size();
        do_start(2);
        wait_done("t3_done", 400, cyc);
        check("t3_strobes", n_strobe - s0, 2);
        check("t3_idx0", q_i[qb], 0);
        check("t3_idx1", q_i[qb+1], 1);
        check("t3_lanes0", q_l[qb], c_D);
        check("t3_lanes1", q_l[qb+1], c_L);

        // Test 4: looping song
        load(0, 2, c_U);
        loop = 1'b1;
        s0 = n_strobe; l0 = n_lap;
        do_start(1);
        repeat (485) @(negedge clk);
        check("t4_laps", n_lap - l0, 3);
        check("t4_strobes", n_strobe - s0, 3);
        check("t4_not_done", done, 0);
        loop = 1'b0;
        wait_done("t4_done", 200, cyc);

        // Test 5: asynchronous reset mid-hold
        load(0, 5, c_R); load(1, 10, c_L); load(2, 12, c_U);
        do_start(3);
        wait_strobe("t5_fire", 100);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1 check("t5_async", 32'(dut_vec()), 0);
        @(negedge clk);
        rst = 1'b1;
        qb = q_l.size();
        do_start(3);
        wait_strobe("t5_refire", 100);
        check("t5_idx", q_i[qb], 0);
        check("t5_lanes", q_l[qb], c_R);
        wait_done("t5_done", 400, cyc);

        // Test 6: write while busy is ignored; empty song still runs full length
        load(0, 8, c_D); load(1, 3, c_L);
        s0 = n_strobe;
        do_start(0);
        repeat (10) @(negedge clk);
        load(1, 0, 4'b1111);
        wait_done("t6_done", 400, cyc);
        check("t6_len", cyc + 11, SONG * CPM);
        check("t6_strobes", n_strobe - s0, 0);
        qb = q_l.size();
        do_start(2);
        wait_done("t6_replay", 400, cyc);
        check("t6_entry1", q_l[qb+1], c_L);

        // Random play
        for (int s = 0; s < 6; s++) begin
            for (int a = 0; a < DEPTH; a++)
                load(a, int'($urandom_range(0, 45)), 4'($urandom));
            do_start(int'($urandom_range(0, 15)));
            for (int c = 0; c < 300; c++) begin
                pause = ($urandom_range(0, 9) == 0);
                loop = (s % 2 == 1);
                start = ($urandom_range(0, 199) == 0);
                step_count = (AW + 1)'($urandom_range(0, 15));
                load_en = ($urandom_range(0, 19) == 0);
                load_addr = AW'($urandom);
                load_time = TW'($urandom_range(0, 45));
                load_lanes = 4'($urandom);
                @(negedge clk);
            end
            start = 1'b0; load_en = 1'b0; pause = 1'b0; loop = 1'b0;
            wait_done("rand_done", 400, cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
